// File: rtl/id_stage_pipe.sv
// RV32/RV64 decode stage: decodes integer ALU, LUI/AUIPC and load/store, resolves
// operands through prioritised forwarding, and registers one bundle for EX under valid/ready.
module id_stage_pipe #(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             inst,
  input  logic [XLEN-1:0]         pc,
  input  logic                    flush,
  output logic [4:0]              reg1_addr,
  output logic [4:0]              reg2_addr,
  input  logic [XLEN-1:0]         reg1_data,
  input  logic [XLEN-1:0]         reg2_data,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [5*NUM_FWD-1:0]    fwd_addr,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    ex_load,
  input  logic [4:0]              ex_load_rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_alusel,
  output logic [2:0]              out_opclass,
  output logic                    out_word,
  output logic [XLEN-1:0]         out_op1,
  output logic [XLEN-1:0]         out_op2,
  output logic [XLEN-1:0]         out_sdata,
  output logic [4:0]              out_rd,
  output logic                    out_we,
  output logic                    out_mem_valid,
  output logic                    out_mem_rw,
  output logic                    stall
);

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;

  localparam logic [2:0] CLS_ALU     = 3'd0;
  localparam logic [2:0] CLS_LOAD    = 3'd1;
  localparam logic [2:0] CLS_STORE   = 3'd2;
  localparam logic [2:0] CLS_LUI     = 3'd3;
  localparam logic [2:0] CLS_AUIPC   = 3'd4;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  typedef struct packed {
    logic            valid;
    logic [3:0]      alusel;
    logic [2:0]      opclass;
    logic            word;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] sdata;
    logic [4:0]      rd;
    logic            we;
    logic            mem_valid;
    logic            mem_rw;
  } bundle_t;

  bundle_t bundle_q, bundle_d, dec;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [4:0]         rs1, rs2, rd;
  logic [XLEN-1:0]    rs1_val, rs2_val;
  logic [NUM_FWD-1:0] hit1, hit2;
  logic [63:0]        imm_i64, imm_s64, imm_u64;
  logic [XLEN-1:0]    imm_i, imm_s, imm_u;
  logic               use1, use2, illegal, hazard, advance;

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign rs1       = inst[19:15];
  assign rs2       = inst[24:20];
  assign rd        = inst[11:7];
  assign reg1_addr = rs1;
  assign reg2_addr = rs2;

  // Build immediates at 64 bits and truncate, so XLEN=32 needs no zero-width replication.
  assign imm_i64 = {{52{inst[31]}}, inst[31:20]};
  assign imm_s64 = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u64 = {{32{inst[31]}}, inst[31:12], 12'b0};
  assign imm_i   = imm_i64[XLEN-1:0];
  assign imm_s   = imm_s64[XLEN-1:0];
  assign imm_u   = imm_u64[XLEN-1:0];

  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
      assign hit1[gi] = fwd_we[gi] && (fwd_addr[5*gi +: 5] == rs1);
      assign hit2[gi] = fwd_we[gi] && (fwd_addr[5*gi +: 5] == rs2);
    end
  endgenerate

  // Walk from oldest to youngest so the lowest matching index is the last writer.
  always_comb begin
    rs1_val = reg1_data;
    rs2_val = reg2_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (hit1[i]) rs1_val = fwd_data[XLEN*i +: XLEN];
      if (hit2[i]) rs2_val = fwd_data[XLEN*i +: XLEN];
    end
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.rd     = rd;
    dec.op1    = rs1_val;
    dec.alusel = {1'b0, funct3};
    use1       = 1'b1;
    use2       = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP32: begin
        dec.opclass = CLS_ALU;
        dec.op2     = rs2_val;
        dec.alusel  = {inst[30], funct3};
        dec.word    = (opcode == OPC_OP32);
        use2        = 1'b1;
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        dec.opclass = CLS_ALU;
        dec.op2     = imm_i;
        dec.alusel  = {(funct3 == 3'b101) & inst[30], funct3};
        dec.word    = (opcode == OPC_OPIMM32);
      end
      OPC_LOAD: begin
        dec.opclass   = CLS_LOAD;
        dec.op2       = imm_i;
        dec.mem_valid = 1'b1;
      end
      OPC_STORE: begin
        dec.opclass   = CLS_STORE;
        dec.op2       = imm_s;
        dec.sdata     = rs2_val;
        dec.rd        = 5'd0;
        dec.mem_valid = 1'b1;
        dec.mem_rw    = 1'b1;
        use2          = 1'b1;
      end
      OPC_LUI: begin
        dec.opclass = CLS_LUI;
        dec.op1     = '0;
        dec.op2     = imm_u;
        dec.alusel  = 4'd0;
        use1        = 1'b0;
      end
      OPC_AUIPC: begin
        dec.opclass = CLS_AUIPC;
        dec.op1     = pc;
        dec.op2     = imm_u;
        dec.alusel  = 4'd0;
        use1        = 1'b0;
      end
      default: illegal = 1'b1;
    endcase
    if ((XLEN == 32) && ((opcode == OPC_OP32) || (opcode == OPC_OPIMM32))) illegal = 1'b1;
    if (illegal) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.opclass = CLS_ILLEGAL;
      use2        = 1'b0;
    end
    dec.we = (dec.rd != 5'd0) && (dec.opclass != CLS_STORE) && (dec.opclass != CLS_ILLEGAL);
  end

  assign advance  = out_ready | ~bundle_q.valid;
  assign hazard   = in_valid & ex_load & (ex_load_rd != 5'd0) &
                    ((use1 & (rs1 == ex_load_rd)) | (use2 & (rs2 == ex_load_rd)));
  assign stall    = hazard;
  assign in_ready = advance & ~hazard & ~flush;

  always_comb begin
    bundle_d = bundle_q;
    if (flush) begin
      bundle_d.valid = 1'b0;
    end else if (advance) begin
      if (in_valid && !hazard) bundle_d = dec;
      else                     bundle_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bundle_q <= '0;
    else     bundle_q <= bundle_d;
  end

  assign out_valid     = bundle_q.valid;
  assign out_alusel    = bundle_q.alusel;
  assign out_opclass   = bundle_q.opclass;
  assign out_word      = bundle_q.word;
  assign out_op1       = bundle_q.op1;
  assign out_op2       = bundle_q.op2;
  assign out_sdata     = bundle_q.sdata;
  assign out_rd        = bundle_q.rd;
  assign out_we        = bundle_q.we;
  assign out_mem_valid = bundle_q.mem_valid;
  assign out_mem_rw    = bundle_q.mem_rw;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe (XLEN=64, NUM_FWD=2): expected bundles are queued
// on acceptance and compared when EX takes them.
module tb_id_stage_pipe;

  localparam int XLEN = 64;
  localparam int NF   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc, reg1_data, reg2_data;
  logic [4:0]      reg1_addr, reg2_addr, ex_load_rd, out_rd;
  logic [NF-1:0]   fwd_we;
  logic [5*NF-1:0] fwd_addr;
  logic [XLEN*NF-1:0] fwd_data;
  logic            ex_load, out_word, out_we, out_mem_valid, out_mem_rw, stall;
  logic [3:0]      out_alusel;
  logic [2:0]      out_opclass;
  logic [XLEN-1:0] out_op1, out_op2, out_sdata;

  id_stage_pipe #(.XLEN(XLEN), .NUM_FWD(NF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
    .flush(flush), .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .reg1_data(reg1_data),
    .reg2_data(reg2_data), .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .ex_load(ex_load), .ex_load_rd(ex_load_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_alusel(out_alusel), .out_opclass(out_opclass), .out_word(out_word), .out_op1(out_op1),
    .out_op2(out_op2), .out_sdata(out_sdata), .out_rd(out_rd), .out_we(out_we),
    .out_mem_valid(out_mem_valid), .out_mem_rw(out_mem_rw), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  alusel;
    logic [2:0]  opclass;
    logic        word;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] sdata;
    logic [4:0]  rd;
    logic        we;
    logic        mem_valid;
    logic        mem_rw;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic exp_t mk(input logic [3:0] alusel, input logic [2:0] opclass, input logic word,
                              input logic [63:0] op1, input logic [63:0] op2, input logic [63:0] sdata,
                              input logic [4:0] rd, input logic we, input logic mv, input logic rw);
    exp_t e;
    e.alusel = alusel; e.opclass = opclass; e.word = word; e.op1 = op1; e.op2 = op2;
    e.sdata = sdata; e.rd = rd; e.we = we; e.mem_valid = mv; e.mem_rw = rw;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_bundle();
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_bundle", 64'(out_valid), 64'd0);
    end else begin
      e = sb.pop_front();
      chk("alusel", 64'(out_alusel), 64'(e.alusel));
      chk("opclass", 64'(out_opclass), 64'(e.opclass));
      chk("word", 64'(out_word), 64'(e.word));
      chk("op1", out_op1, e.op1);
      chk("op2", out_op2, e.op2);
      chk("sdata", out_sdata, e.sdata);
      chk("rd", 64'(out_rd), 64'(e.rd));
      chk("we", 64'(out_we), 64'(e.we));
      chk("mem_valid", 64'(out_mem_valid), 64'(e.mem_valid));
      chk("mem_rw", 64'(out_mem_rw), 64'(e.mem_rw));
      $display("bundle rd=%0d opclass=%0d op1=%h op2=%h", out_rd, out_opclass, out_op1, out_op2);
    end
  endtask

  // Settle inputs, retire/kill the current output, record acceptance, then cross one edge.
  task automatic tick();
    #1;
    if (out_valid) begin
      if (flush) begin
        if (sb.size() > 0) void'(sb.pop_front());
      end else if (out_ready) begin
        chk_bundle();
      end
    end
    if (in_valid && in_ready) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [63:0] r1, input logic [63:0] r2, input exp_t e);
    in_valid  = 1'b1;
    inst      = i;
    reg1_data = r1;
    reg2_data = r2;
    cur_exp   = e;
  endtask

  initial begin
    in_valid = 0; inst = 0; pc = 64'h1000; flush = 0; reg1_data = 0; reg2_data = 0;
    fwd_we = 0; fwd_addr = 0; fwd_data = 0; ex_load = 0; ex_load_rd = 0; out_ready = 1;
    cur_exp = '0;
    #1 rst = 1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_op1", out_op1, 64'd0);
    chk("rst_we", 64'(out_we), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst = 0;

    // add x3,x1,x2 from the regfile
    drive(32'h002081B3, 64'd5, 64'd7, mk(4'b0000, 3'd0, 0, 64'd5, 64'd7, 0, 5'd3, 1, 0, 0));
    #1;
    chk("reg1_addr", 64'(reg1_addr), 64'd1);
    chk("reg2_addr", 64'(reg2_addr), 64'd2);
    tick();
    chk("latency_valid", 64'(out_valid), 64'd1);

    // both sources forward x1; index 0 wins
    fwd_we = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {64'hBB, 64'hAA};
    drive(32'h002081B3, 64'd5, 64'd7, mk(4'b0000, 3'd0, 0, 64'hAA, 64'd7, 0, 5'd3, 1, 0, 0));
    tick();

    // forwarding to x0 must not override the zero register
    fwd_we = 2'b01; fwd_addr = {5'd0, 5'd0}; fwd_data = {64'h0, 64'h55};
    drive(32'h002001B3, 64'd9, 64'd7, mk(4'b0000, 3'd0, 0, 64'd0, 64'd7, 0, 5'd3, 1, 0, 0));
    tick();
    fwd_we = 0;

    // load-use hazard on x1
    ex_load = 1; ex_load_rd = 5'd1;
    drive(32'h002081B3, 64'd5, 64'd7, mk(4'b0000, 3'd0, 0, 64'd5, 64'd7, 0, 5'd3, 1, 0, 0));
    #1;
    chk("hazard_stall", 64'(stall), 64'd1);
    chk("hazard_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("bubble_valid", 64'(out_valid), 64'd0);
    ex_load = 0;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    tick();

    // backpressure: held bundle is the add (5,7,x3); sub waits upstream
    out_ready = 0;
    drive(32'h40208233, 64'd5, 64'd7, mk(4'b1000, 3'd0, 0, 64'd5, 64'd7, 0, 5'd4, 1, 0, 0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_op1", out_op1, 64'd5);
      chk("hold_rd", 64'(out_rd), 64'd3);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    tick();

    // sw x2,-4(x1)
    drive(32'hFE20AE23, 64'd5, 64'd7,
          mk(4'b0010, 3'd2, 0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd7, 5'd0, 0, 1, 1));
    tick();
    // addi x6,x1,-1
    drive(32'hFFF08313, 64'd5, 64'd7, mk(4'b0000, 3'd0, 0, 64'd5, '1, 0, 5'd6, 1, 0, 0));
    tick();
    // srai x7,x1,3 sets alt
    drive(32'h4030D393, 64'd5, 64'd7, mk(4'b1101, 3'd0, 0, 64'd5, 64'h403, 0, 5'd7, 1, 0, 0));
    tick();
    // addw x8,x1,x2
    drive(32'h0020843B, 64'd5, 64'd7, mk(4'b0000, 3'd0, 1, 64'd5, 64'd7, 0, 5'd8, 1, 0, 0));
    tick();
    // ld x9,8(x1)
    drive(32'h0080B483, 64'd5, 64'd7, mk(4'b0011, 3'd1, 0, 64'd5, 64'd8, 0, 5'd9, 1, 1, 0));
    tick();
    // auipc x10,0x1 at pc 0x1000
    drive(32'h00001517, 64'd5, 64'd7, mk(4'b0000, 3'd4, 0, 64'h1000, 64'h1000, 0, 5'd10, 1, 0, 0));
    tick();
    // unknown opcode
    drive(32'hFFFFFFFF, 64'd5, 64'd7, mk(4'b0000, 3'd7, 0, 64'd0, 64'd0, 0, 5'd0, 0, 0, 0));
    tick();
    // addi x0,x1,1 does not write
    drive(32'h00108013, 64'd5, 64'd7, mk(4'b0000, 3'd0, 0, 64'd5, 64'd1, 0, 5'd0, 0, 0, 0));
    tick();
    // lui x5,0x80000
    drive(32'h800002B7, 64'd5, 64'd7,
          mk(4'b0000, 3'd3, 0, 64'd0, 64'hFFFF_FFFF_8000_0000, 0, 5'd5, 1, 0, 0));
    tick();
    chk("lui_valid", 64'(out_valid), 64'd1);

    // flush kills the lui bundle and the instruction on the input
    flush = 1;
    drive(32'h00108013, 64'd5, 64'd7, mk(4'b0000, 3'd0, 0, 64'd5, 64'd1, 0, 5'd0, 0, 0, 0));
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    flush = 0;

    // reset mid-operation drops the in-flight bundle immediately
    drive(32'h002081B3, 64'd5, 64'd7, mk(4'b0000, 3'd0, 0, 64'd5, 64'd7, 0, 5'd3, 1, 0, 0));
    tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_op1", out_op1, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 0;

    // recovery after reset
    drive(32'h002081B3, 64'd3, 64'd4, mk(4'b0000, 3'd0, 0, 64'd3, 64'd4, 0, 5'd3, 1, 0, 0));
    tick();
    in_valid = 0;
    tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
